mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/risc_mem_pkg.sv | 7 +
 rtl/mem_access_ctrl.sv | 89 ++++++++
 tb/tb_mem_access_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/risc_mem_pkg.sv
// risc_mem_pkg: shared widths, default memory depth and controller state encoding.
package risc_mem_pkg;
    localparam int DATA_W         = 16;
    localparam int ADDR_W         = 16;
    localparam int ADDR_LIMIT_DEF = 64;
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, WAIT, RESP} state_t;
endpackage

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences single load/store requests onto a synchronous data memory.
module mem_access_ctrl
    import risc_mem_pkg::*;
#(
    parameter int ADDR_LIMIT = ADDR_LIMIT_DEF,
    parameter int READ_WAIT  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_wea,
    input  logic [DATA_W-1:0] mem_dout
);
    localparam logic [ADDR_W:0] LIMIT     = (ADDR_W+1)'(ADDR_LIMIT);
    localparam logic [2:0]      WAIT_INIT = 3'(READ_WAIT - 1);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              we_q, err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q, rdata_q;
    logic              accept, in_range;

    assign accept   = (state_q == IDLE) && req_valid;
    assign in_range = {1'b0, req_addr} < LIMIT;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:    state_d = req_valid ? (in_range ? SETUP : RESP) : IDLE;
            SETUP: begin
                state_d = we_q ? STROBE : WAIT;
                cnt_d   = we_q ? cnt_q : WAIT_INIT;
            end
            STROBE:  state_d = HOLD;
            HOLD:    state_d = RESP;
            WAIT: begin
                state_d = (cnt_q == 3'd0) ? RESP : WAIT;
                cnt_d   = (cnt_q == 3'd0) ? cnt_q : cnt_q - 3'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Out-of-range requests never touch the memory-facing registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q  <= req_we;
                err_q <= !in_range;
            end
            if (accept && in_range) begin
                addr_q <= req_addr;
                din_q  <= req_wdata;
            end
            if (state_q == WAIT && cnt_q == 3'd0)
                rdata_q <= mem_dout;
        end
    end

    assign req_ready = state_q == IDLE;
    assign rsp_valid = state_q == RESP;
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = rsp_err ? '0 : rdata_q;
    assign mem_wea   = state_q == STROBE;
    assign mem_addr  = addr_q;
    assign mem_din   = din_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: random and directed requests checked by a queue scoreboard against a behavioural model.
module tb_mem_access_ctrl;
    typedef struct {
        logic        we;
        logic        err;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] rdata;
        logic [15:0] old;
        int          acc;
        int          lat;
    } exp_t;

    logic        clk = 0, reset = 0;
    logic        req_valid = 0, req_we = 0;
    logic [15:0] req_addr = 0, req_wdata = 0;
    logic        req_ready, rsp_valid, rsp_err, mem_wea;
    logic [15:0] rsp_rdata, mem_addr, mem_din, mem_dout;

    logic        v2 = 0;
    logic [15:0] a2 = 0;
    logic        r2, rv2, re2, mw2;
    logic [15:0] rd2, ma2, md2, dout2;

    logic [15:0] mem [64];
    logic [15:0] ref_mem [64];
    exp_t        sb[$];
    int          cyc = 0, last_resp = -1;
    logic [15:0] last_load = 0, exp_maddr = 0, exp_mdin = 0;
    int          vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_wea(mem_wea), .mem_dout(mem_dout)
    );

    mem_access_ctrl #(.READ_WAIT(4)) dut4 (
        .clk(clk), .reset(reset), .req_valid(v2), .req_ready(r2),
        .req_we(1'b0), .req_addr(a2), .req_wdata(16'h0),
        .rsp_valid(rv2), .rsp_rdata(rd2), .rsp_err(re2),
        .mem_addr(ma2), .mem_din(md2), .mem_wea(mw2), .mem_dout(dout2)
    );

    assign mem_dout = (mem_addr < 16'd64) ? mem[mem_addr[5:0]] : 16'h0;
    assign dout2    = (ma2 == 16'd16) ? 16'h0101 : 16'h0;

    always @(posedge clk)
        if (mem_wea && mem_addr < 16'd64) mem[mem_addr[5:0]] = mem_din;

    function automatic void chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Reference model: expected response computed when the request is accepted.
    always @(posedge clk) begin
        if (reset) begin
            if (sb.size() > 0 && sb[0].we && !sb[0].err) ref_mem[sb[0].addr[5:0]] = sb[0].old;
            sb.delete();
            last_resp = -1;
            last_load = 0;
            exp_maddr = 0;
            exp_mdin  = 0;
        end else if (req_valid && req_ready) begin
            exp_t e;
            e.we = req_we; e.addr = req_addr; e.data = req_wdata; e.acc = cyc;
            e.err = req_addr >= 16'd64; e.old = 0;
            if (e.err) begin
                e.lat = 1; e.rdata = 0;
            end else begin
                exp_maddr = req_addr;
                exp_mdin  = req_wdata;
                if (e.we) begin
                    e.lat = 4; e.rdata = last_load;
                    e.old = ref_mem[req_addr[5:0]];
                    ref_mem[req_addr[5:0]] = req_wdata;
                end else begin
                    e.lat = 3; e.rdata = ref_mem[req_addr[5:0]];
                    last_load = e.rdata;
                end
            end
            sb.push_back(e);
            last_resp = cyc + e.lat;
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (!reset) begin
            bit exp_v, exp_w;
            exp_v = sb.size() > 0 && cyc == sb[0].acc + sb[0].lat;
            exp_w = sb.size() > 0 && sb[0].we && !sb[0].err && cyc == sb[0].acc + 2;
            chk(req_ready == (cyc > last_resp), "req_ready", req_ready, cyc > last_resp);
            chk(mem_addr == exp_maddr, "mem_addr", mem_addr, exp_maddr);
            chk(mem_din == exp_mdin, "mem_din", mem_din, exp_mdin);
            chk(mem_wea == exp_w, "mem_wea", mem_wea, exp_w);
            chk(rsp_valid == exp_v, "rsp_valid", rsp_valid, exp_v);
            if (exp_v) begin
                exp_t e;
                e = sb.pop_front();
                if (rsp_valid) begin
                    chk(rsp_err == e.err, "rsp_err", rsp_err, e.err);
                    chk(rsp_rdata == e.rdata, "rsp_rdata", rsp_rdata, e.rdata);
                end
            end
        end
    end

    // mode 0: valid low while busy, 1: random noise while busy, 2: request held high.
    task automatic issue(input logic we, input logic [15:0] a, input logic [15:0] d, input int mode, output int acc);
        acc = -1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (req_ready) begin
                req_valid = 1; req_we = we; req_addr = a; req_wdata = d; acc = cyc;
                @(posedge clk);
                #1;
                if (mode == 0) req_valid = 0;
                return;
            end
            if (mode == 1) begin
                req_valid = 1'($urandom); req_we = 1'($urandom);
                req_addr = 16'($urandom); req_wdata = 16'($urandom);
            end else begin
                req_valid = (mode == 2); req_we = we; req_addr = a; req_wdata = d;
            end
        end
        chk(0, "accept_timeout", 0, 1);
    endtask

    initial begin
        int acc, b1, b2, n, r;
        logic [15:0] a;
        for (int i = 0; i < 64; i++) begin
            mem[i] = 16'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[16] = 16'h0101;
        ref_mem[16] = 16'h0101;
        #2 reset = 1;
        #1;
        chk(rsp_valid == 0, "rst_rsp_valid", rsp_valid, 0);
        chk(mem_wea == 0, "rst_mem_wea", mem_wea, 0);
        repeat (2) @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk(req_ready == 1, "rst_req_ready", req_ready, 1);
        chk(rsp_rdata == 0, "rst_rsp_rdata", rsp_rdata, 0);
        chk(rsp_err == 0, "rst_rsp_err", rsp_err, 0);
        chk(mem_addr == 0, "rst_mem_addr", mem_addr, 0);
        chk(mem_din == 0, "rst_mem_din", mem_din, 0);

        chk(r2 == 1, "rw4_ready", r2, 1);
        v2 = 1; a2 = 16;
        @(posedge clk);
        #1 v2 = 0;
        n = 0;
        while (!rv2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(n == 6, "rw4_latency", n, 6);
        chk(rd2 == 16'h0101, "rw4_rdata", rd2, 16'h0101);
        chk(re2 == 0, "rw4_err", re2, 0);

        issue(1, 16'd5, 16'hA5A5, 0, acc);
        issue(0, 16'd16, 16'h0, 0, acc);
        issue(0, 16'd64, 16'h0, 0, acc);
        issue(0, 16'hFFFF, 16'h0, 1, acc);
        issue(1, 16'd64, 16'h1234, 0, acc);
        issue(0, 16'd5, 16'h0, 0, acc);
        issue(1, 16'd63, 16'h00FF, 2, b1);
        issue(0, 16'd63, 16'h0, 2, b2);
        req_valid = 0;
        chk(b2 == b1 + 5, "b2b_gap", b2 - b1, 5);

        issue(1, 16'd10, 16'hBEEF, 0, acc);
        @(posedge clk);
        #2;
        chk(mem_wea == 1, "strobe_before_reset", mem_wea, 1);
        reset = 1;
        #1;
        chk(mem_wea == 0, "wea_async_drop", mem_wea, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk(rsp_valid == 0, "rsp_during_reset", rsp_valid, 0);
        end
        reset = 0;
        @(negedge clk);
        chk(req_ready == 1, "ready_after_abort", req_ready, 1);
        chk(mem[10] == ref_mem[10], "aborted_store", mem[10], ref_mem[10]);

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            a = r == 0 ? 16'hFFFF : r == 1 ? 16'd64 : r == 2 ? 16'($urandom_range(65, 65535)) : 16'($urandom_range(0, 63));
            issue(1'($urandom), a, 16'($urandom), $urandom_range(0, 2), acc);
            if ($urandom_range(0, 3) == 0) begin
                req_valid = 0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        req_valid = 0;
        n = 0;
        while (sb.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk(sb.size() == 0, "drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
